// File: rtl/uart_ctrl.sv
// uart_ctrl: bus register window with TX/RX byte FIFOs in front of the uart core.
// Optional macro UART_CTRL_IRQ_EN adds the IRQ_EN register at 0xC and an irq output.
module uart_ctrl #(
  parameter int FIFO_DEPTH = 8,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
`ifdef UART_CTRL_IRQ_EN
  output logic        irq,
`endif
  output logic        rx_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr;
  logic [PTR_W-1:0] tx_rd;
  logic [CNT_W-1:0] tx_cnt;

  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr;
  logic [PTR_W-1:0] rx_rd;
  logic [CNT_W-1:0] rx_cnt;

  logic tx_drop;
  logic rx_overrun;

  logic sel_data;
  logic sel_stat;
  logic sel_irq;
  logic wr_data;
  logic rd_data;
  logic wr_stat;

  logic tx_full;
  logic tx_empty;
  logic tx_push;
  logic tx_pop;
  logic tx_drop_set;

  logic rx_full;
  logic rx_nonempty;
  logic rx_push;
  logic rx_pop;
  logic rx_ovr_set;

  logic [31:0] status;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign sel_data = bus_addr[3:2] == 2'd0;
  assign sel_stat = bus_addr[3:2] == 2'd1;
  assign sel_irq  = bus_addr[3:2] == 2'd3;

  assign wr_data = bus_valid &  bus_we & sel_data;
  assign rd_data = bus_valid & ~bus_we & sel_data;
  assign wr_stat = bus_valid &  bus_we & sel_stat;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

  // TX: a pop in the same cycle frees the slot a full-FIFO write needs
  assign tx_full     = tx_cnt == FULL_CNT;
  assign tx_empty    = tx_cnt == '0;
  assign tx_valid    = ~tx_empty;
  assign tx_data     = tx_mem[tx_rd];
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push     = wr_data & (~tx_full | tx_pop);
  assign tx_drop_set = wr_data & tx_full & ~tx_pop;

  assign rx_ready    = 1'b1;
  assign rx_full     = rx_cnt == FULL_CNT;
  assign rx_nonempty = rx_cnt != '0;
  assign rx_pop      = rd_data & rx_nonempty;
  assign rx_push     = rx_valid & (~rx_full | rx_pop);
  assign rx_ovr_set  = rx_valid & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr] <= bus_wdata[7:0];
    end
    if (rx_push) begin
      rx_mem[rx_wr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_wr <= tx_wr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd <= tx_rd + 1'b1;
      end
      tx_cnt <= tx_cnt + CNT_W'(tx_push) - CNT_W'(tx_pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_wr <= rx_wr + 1'b1;
      end
      if (rx_pop) begin
        rx_rd <= rx_rd + 1'b1;
      end
      rx_cnt <= rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  // sticky flags: a set in the same cycle beats the clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_drop    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      tx_drop    <= tx_drop_set |
                    (tx_drop & ~(wr_stat & bus_wdata[4]));
      rx_overrun <= rx_ovr_set |
                    (rx_overrun & ~(wr_stat & bus_wdata[3]));
    end
  end

  assign status = {16'h0, 8'(rx_cnt), 3'b0,
                   tx_drop, rx_overrun, rx_nonempty,
                   tx_empty, tx_full};

`ifdef UART_CTRL_IRQ_EN
  logic [2:0] irq_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (bus_valid & bus_we & sel_irq) begin
        irq_en <= bus_wdata[2:0];
      end
      irq <= (irq_en[0] & rx_nonempty) |
             (irq_en[1] & tx_empty) |
             (irq_en[2] & (rx_overrun | tx_drop));
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_data: rd_mux = rx_nonempty ? {24'h0, rx_mem[rx_rd]} : '0;
      sel_stat: rd_mux = status;
`ifdef UART_CTRL_IRQ_EN
      sel_irq:  rd_mux = {29'h0, irq_en};
`else
      sel_irq:  rd_mux = '0;
`endif
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= bus_valid;
      bus_rdata <= (bus_valid & ~bus_we) ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: scoreboard bench for uart_ctrl; bus responses and TX bytes
// are checked by monitors against queues filled by the stimulus process.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
`ifdef UART_CTRL_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_tx[$];
  logic        prev_valid = 1'b0;

  uart_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus_valid(bus_valid),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
`ifdef UART_CTRL_IRQ_EN
    .irq(irq),
`endif
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(posedge clk) prev_valid <= bus_valid & rstn;

  // bus monitor: response timing and read data
  always @(negedge clk) begin
    if (prev_valid || bus_ready) begin
      chk("bus_ready_timing", {31'h0, bus_ready}, {31'h0, prev_valid});
    end
    if (bus_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got rdata 0x%08h with no request",
                 bus_rdata);
      end else begin
        chk("bus_rdata", bus_rdata, exp_q.pop_front());
      end
    end
  end

  // TX monitor: every accepted byte must match the queued order
  always @(negedge clk) begin
    if (rstn && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got 0x%02h expected none", tx_data);
      end else begin
        chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic we, input logic [3:0] a,
                     input logic [31:0] wd, input logic [31:0] exp);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = wd;
    exp_q.push_back(we ? 32'h0 : exp);
    tick(1);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b, input logic keep);
    bus(1'b1, 4'h0, {24'hABCDEF, b}, 32'h0);
    if (keep) begin
      exp_tx.push_back(b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("reset_bus_ready", {31'h0, bus_ready}, 32'h0);
    chk("reset_bus_rdata", bus_rdata, 32'h0);
    chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rx_ready_tied", {31'h0, rx_ready}, 32'h1);
    rstn = 1'b1;
    tick(1);

    bus(1'b0, 4'h4, 32'h0, 32'h0000_0002);

    tx_write(8'h41, 1'b1);
    tx_write(8'h42, 1'b1);
    chk("tx_valid_after_wr", {31'h0, tx_valid}, 32'h1);
    chk("tx_data_head", {24'h0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    tick(2);
    tx_ready = 1'b0;
    chk("tx_valid_drained", {31'h0, tx_valid}, 32'h0);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0002);

    for (int i = 0; i < 9; i++) begin
      tx_write(8'(8'h60 + i), i < 8);
    end
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0011);
    bus(1'b1, 4'h4, 32'h10, 32'h0);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0001);
    tx_ready = 1'b1;
    tx_write(8'h70, 1'b1);
    tick(8);
    tx_ready = 1'b0;
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0002);

    rx_send(8'h55);
    rx_send(8'hAA);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0206);
    bus(1'b0, 4'h0, 32'h0, 32'h0000_0055);
    bus(1'b0, 4'h0, 32'h0, 32'h0000_00AA);
    bus(1'b0, 4'h0, 32'h0, 32'h0000_0000);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0002);

    for (int i = 0; i < 8; i++) begin
      rx_send(8'(8'h80 + i));
    end
    rx_send(8'h88);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_080E);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    bus(1'b1, 4'h4, 32'h8, 32'h0);
    rx_valid = 1'b0;
    bus(1'b0, 4'h4, 32'h0, 32'h0000_080E);
    bus(1'b1, 4'h4, 32'h8, 32'h0);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0806);
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    bus(1'b0, 4'h0, 32'h0, 32'h0000_0080);
    rx_valid = 1'b0;
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0806);
    for (int i = 1; i < 8; i++) begin
      bus(1'b0, 4'h0, 32'h0, 32'(8'h80 + i));
    end
    bus(1'b0, 4'h0, 32'h0, 32'h0000_0099);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0002);

    bus(1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0);
    bus(1'b0, 4'h8, 32'h0, 32'h0);
`ifdef UART_CTRL_IRQ_EN
    bus(1'b1, 4'hC, 32'h1, 32'h0);
    bus(1'b0, 4'hC, 32'h0, 32'h1);
    rx_send(8'h31);
    tick(1);
    chk("irq_set", {31'h0, irq}, 32'h1);
    bus(1'b0, 4'h0, 32'h0, 32'h31);
    tick(1);
    chk("irq_clear", {31'h0, irq}, 32'h0);
    bus(1'b1, 4'hC, 32'h0, 32'h0);
`else
    bus(1'b1, 4'hC, 32'h7, 32'h0);
    bus(1'b0, 4'hC, 32'h0, 32'h0);
`endif

    tx_write(8'h11, 1'b0);
    tx_write(8'h22, 1'b0);
    rx_send(8'h33);
    tick(1);
    rstn = 1'b0;
    #1;
    chk("midreset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("midreset_bus_ready", {31'h0, bus_ready}, 32'h0);
    tick(1);
    rstn = 1'b1;
    tick(1);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0002);
    bus(1'b0, 4'h0, 32'h0, 32'h0000_0000);
    tx_ready = 1'b1;
    tick(2);
    tx_ready = 1'b0;

    tick(2);
    chk("bus_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("tx_queue_drained", 32'(exp_tx.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Bus-side controller for the UART core: the initiator that drives the core's tx_valid/tx_data and consumes its rx_valid/rx_data.
- Exposes a small memory-mapped register window to the riscv32 data bus.
- Buffers bytes in a TX FIFO and an RX FIFO so software can queue and drain bytes at bus speed.
- Sits between the CPU bus fabric and the uart core instance.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; power of 2, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived, do not override).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- bus_valid  input  1  bus request strobe, one cycle per access
- bus_we  input  1  1 = write, 0 = read
- bus_addr  input  4  byte offset; bits [1:0] ignored
- bus_wdata  input  32  write data
- bus_rdata  output  32  read data, valid when bus_ready=1
- bus_ready  output  1  response pulse
- tx_valid  output  1  byte available to uart core TX
- tx_data  output  8  byte to transmit
- tx_ready  input  1  uart core TX accepts byte
- rx_valid  input  1  received byte from uart core
- rx_data  input  8  received byte
- rx_ready  output  1  controller accepts received byte

Behaviour:
- Reset values (async on rstn low): all FIFO pointers and counts 0, bus_ready 0, bus_rdata 0, sticky flags 0, tx_valid 0.
- Reset mid-operation discards all queued bytes; no partial state survives.
- Register map:
  - 0x0 DATA: write pushes bus_wdata[7:0] to the TX FIFO; read pops the RX FIFO head into rdata[7:0].
  - 0x4 STATUS (read): bit0 tx_full, bit1 tx_empty, bit2 rx_nonempty, bit3 rx_overrun, bit4 tx_drop, bits[15:8] rx_count, others 0.
  - 0x4 STATUS (write): write-1-to-clear bit3 and bit4; other bits ignored.
  - 0x8 RSVD: reads 0, writes ignored. 0xC: see Optional Feature, otherwise reads 0.
- Bus timing: every access with bus_valid=1 gets bus_ready=1 exactly one cycle later, with bus_rdata registered in that same cycle. No wait states.
  - bus_rdata returns 0 on write responses.
  - Back-to-back accesses are allowed every cycle.
- TX path:
  - tx_valid = TX count != 0; tx_data = TX head (combinational from FIFO storage).
  - Pop when tx_valid && tx_ready.
  - A write to DATA while full with no pop in the same cycle drops the byte and sets tx_drop.
  - Write while full coincident with a pop: the byte is accepted and the count is unchanged.
- RX path:
  - rx_ready is tied 1; the core never stalls.
  - Push when rx_valid. If full and no bus pop in the same cycle: byte dropped, rx_overrun set.
  - Full with a coincident bus pop: byte accepted.
- A DATA read with the RX FIFO empty returns 0 and has no pop or side effect.
- Simultaneous push and pop on the same FIFO: both occur and the count holds. Pointers wrap modulo FIFO_DEPTH.
- The pop-on-read happens in the request cycle. The popped head byte is what appears in bus_rdata the next cycle.
- W1C versus set in the same cycle: set wins.

Optional Feature:
- Macro: UART_CTRL_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0, registered).
  - Adds register 0xC IRQ_EN: bit0 rx_nonempty enable, bit1 tx_empty enable, bit2 error enable; read/write, reset 0.
  - irq = (en0&rx_nonempty) | (en1&tx_empty) | (en2&(rx_overrun|tx_drop)), registered one cycle.
- Undefined: no irq port; 0xC reads 0 and writes are ignored.

Test Plan:
- Reset, then read STATUS -> rdata=0x00000002 (tx_empty only), bus_ready one cycle after bus_valid.
- tx_ready held 0, write 0x41,0x42 to DATA -> tx_valid=1, tx_data=0x41. Raise tx_ready for 2 cycles -> bytes 0x41 then 0x42 popped, then tx_valid=0.
- tx_ready held 0, write 9 bytes (FIFO_DEPTH=8) -> STATUS bit0=1, bit4=1. Write 0x10 to STATUS -> bit4 cleared.
- Drive rx_valid with 0x55, 0xAA -> STATUS rx_count=2. Two DATA reads -> 0x55, 0xAA. Third read -> 0, no underflow.
- Fill RX with 8 bytes, send a 9th alone -> rx_overrun=1. 9th coincident with a DATA read -> accepted, no overrun.
- With UART_CTRL_IRQ_EN defined: write IRQ_EN=1, push one RX byte -> irq=1 one cycle after the push. Read DATA -> irq=0.
